// File: rtl/adv_video_timing.sv
// Raster timing generator and pixel pacer feeding the ADV7511 DDR output stage.
// Optional colour-bar source is compiled in with `define ADV_TIMING_COLORBAR_EN.
module adv_video_timing #(
    parameter int          H_ACTIVE        = 1280,
    parameter int          H_FP            = 24,
    parameter int          H_SYNC          = 32,
    parameter int          H_BP            = 24,
    parameter int          V_ACTIVE        = 720,
    parameter int          V_FP            = 68,
    parameter int          V_SYNC          = 5,
    parameter int          V_BP            = 13,
    parameter bit          HS_POL          = 1'b1,
    parameter bit          VS_POL          = 1'b1,
    parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF00FF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        test_mode,
    input  logic        clr_underflow,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        pix_ready,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [23:0] data,
    output logic        sof,
    output logic        underflow
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active;
    logic          hs_on;
    logic          vs_on;
    logic          bar_mode;
    logic [23:0]   bar_color;
    logic [23:0]   next_data;
    logic          uf_event;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (int'(h_cnt) == H_TOTAL - 1) begin
            h_cnt <= '0;
            v_cnt <= (int'(v_cnt) == V_TOTAL - 1) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign active = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    assign hs_on  = (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
    assign vs_on  = (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);

`ifdef ADV_TIMING_COLORBAR_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [2:0] bar_idx;

    // Index wraps past 7 in blanking; harmless since bars are only shown while active.
    assign bar_idx  = 3'(int'(h_cnt) / BAR_W);
    assign bar_mode = test_mode;

    always_comb begin
        case (bar_idx)
            3'd0:    bar_color = 24'hFFFFFF;
            3'd1:    bar_color = 24'hFFFF00;
            3'd2:    bar_color = 24'h00FFFF;
            3'd3:    bar_color = 24'h00FF00;
            3'd4:    bar_color = 24'hFF00FF;
            3'd5:    bar_color = 24'hFF0000;
            3'd6:    bar_color = 24'h0000FF;
            default: bar_color = 24'h000000;
        endcase
    end
`else
    logic unused_test_mode;

    assign unused_test_mode = test_mode;
    assign bar_mode         = 1'b0;
    assign bar_color        = 24'h000000;
`endif

    // Gated by reset_n so the upstream FIFO never sees a pull while the counters sit at (0,0) in reset.
    assign pix_ready = reset_n && enable && active && !bar_mode;
    assign uf_event  = enable && active && !bar_mode && !pix_valid;

    // NOTE: default assignment first so no path through this block infers a latch.
    always_comb begin
        next_data = 24'h000000;
        if (active) begin
            if (bar_mode)       next_data = bar_color;
            else if (pix_valid) next_data = pix_data;
            else                next_data = UNDERFLOW_COLOR;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de    <= 1'b0;
            data  <= 24'h000000;
            sof   <= 1'b0;
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
        end else if (!enable) begin
            de    <= 1'b0;
            data  <= 24'h000000;
            sof   <= 1'b0;
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
        end else begin
            de    <= active;
            data  <= next_data;
            sof   <= (h_cnt == '0) && (v_cnt == '0);
            hsync <= hs_on ? HS_POL : ~HS_POL;
            vsync <= vs_on ? VS_POL : ~VS_POL;
        end
    end

    // Sticky status: a new underflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)           underflow <= 1'b0;
        else if (uf_event)      underflow <= 1'b1;
        else if (clr_underflow) underflow <= 1'b0;
    end
endmodule
